// File: rtl/hs_nand_pkg.sv
// Shared constants for the NAND-only half subtractor: the node numbering of
// the five NAND2 gates that make up one lane.
package hs_nand_pkg;

    // Number of NAND2 gates in one lane.
    localparam int unsigned GATES_PER_LANE = 5;

    // Node indices inside a lane's gate-output vector.
    localparam int unsigned NODE_N1 = 0;  // NAND(a, b)
    localparam int unsigned NODE_N2 = 1;  // NAND(a, n1)
    localparam int unsigned NODE_N3 = 2;  // NAND(b, n1)
    localparam int unsigned NODE_D  = 3;  // NAND(n2, n3) = a ^ b
    localparam int unsigned NODE_BW = 4;  // NAND(n3, n3) = ~a & b

endpackage

// File: rtl/hs_nand_nand2_gate.sv
// Two-input NAND gate; the only logic primitive used by the half subtractor.
module nand2_gate (
    input  logic in0,
    input  logic in1,
    output logic y
);

    assign y = ~(in0 & in1);

endmodule

// File: rtl/hs_nand.sv
// Per-lane half subtractor (a - b) built from five NAND2 gates per lane, with
// an optional output register stage.
module hs_nand
    import hs_nand_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] bo
);

    // Gate outputs of every lane, indexed by the NODE_* constants.
    logic [GATES_PER_LANE-1:0] node_s [WIDTH];
    logic [WIDTH-1:0]          d_s;
    logic [WIDTH-1:0]          bw_s;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            nand2_gate u_n1 (.in0(a[i]),                 .in1(b[i]),                 .y(node_s[i][NODE_N1]));
            nand2_gate u_n2 (.in0(a[i]),                 .in1(node_s[i][NODE_N1]),   .y(node_s[i][NODE_N2]));
            nand2_gate u_n3 (.in0(b[i]),                 .in1(node_s[i][NODE_N1]),   .y(node_s[i][NODE_N3]));
            nand2_gate u_d  (.in0(node_s[i][NODE_N2]),   .in1(node_s[i][NODE_N3]),   .y(node_s[i][NODE_D]));
            // Borrow is NAND(n3,n3) = ~n3 = ~a & b.
            nand2_gate u_bw (.in0(node_s[i][NODE_N3]),   .in1(node_s[i][NODE_N3]),   .y(node_s[i][NODE_BW]));

            assign d_s[i]  = node_s[i][NODE_D];
            assign bw_s[i] = node_s[i][NODE_BW];
        end
    endgenerate

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] diff_d;
            logic [WIDTH-1:0] diff_q;
            logic [WIDTH-1:0] bo_d;
            logic [WIDTH-1:0] bo_q;

            // Next output state: cleared while rst_n is low, else the gate results.
            always_comb begin
                diff_d = {WIDTH{1'b0}};
                bo_d   = {WIDTH{1'b0}};
                if (!rst_n) begin
                    diff_d = {WIDTH{1'b0}};
                    bo_d   = {WIDTH{1'b0}};
                end else begin
                    diff_d = d_s;
                    bo_d   = bw_s;
                end
            end

            // Output register; reset is folded into the _d logic so it is synchronous.
            always_ff @(posedge clk) begin
                diff_q <= diff_d;
                bo_q   <= bo_d;
            end

            assign diff = diff_q;
            assign bo   = bo_q;
        end else begin : g_comb
            // Clock and reset have no function in the combinational build.
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ rst_n;

            assign diff = d_s;
            assign bo   = bw_s;
        end
    endgenerate

endmodule

// File: tb/tb_hs_nand.sv
// Self-checking bench for hs_nand: exhaustive lane sweep, latency, reset
// behaviour, lane independence and randomized streams against an arithmetic
// reference model (per-lane a - b: nonzero result -> diff, negative -> borrow).
module tb_hs_nand;

    logic clk;
    logic rst_n;

    logic       a_c1, b_c1, diff_c1, bo_c1;
    logic       a_r1, b_r1, diff_r1, bo_r1;
    logic [3:0] a_r4, b_r4, diff_r4, bo_r4;
    logic [7:0] a_c8, b_c8, diff_c8, bo_c8;
    logic [7:0] a_r8, b_r8, diff_r8, bo_r8;

    int checks;
    int failures;

    hs_nand #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (.clk(clk), .rst_n(rst_n), .a(a_c1), .b(b_c1), .diff(diff_c1), .bo(bo_c1));
    hs_nand #(.WIDTH(1), .REG_OUT(1'b1)) u_r1 (.clk(clk), .rst_n(rst_n), .a(a_r1), .b(b_r1), .diff(diff_r1), .bo(bo_r1));
    hs_nand #(.WIDTH(4), .REG_OUT(1'b1)) u_r4 (.clk(clk), .rst_n(rst_n), .a(a_r4), .b(b_r4), .diff(diff_r4), .bo(bo_r4));
    hs_nand #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (.clk(clk), .rst_n(rst_n), .a(a_c8), .b(b_c8), .diff(diff_c8), .bo(bo_c8));
    hs_nand #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (.clk(clk), .rst_n(rst_n), .a(a_r8), .b(b_r8), .diff(diff_r8), .bo(bo_r8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: subtract each lane as integers; difference bit is whether the
    // result is nonzero (odd magnitude), borrow is whether it went negative.
    function automatic logic [7:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            int s;
            s = int'(x[i]) - int'(y[i]);
            r[i] = (s != 0);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_bo(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            int s;
            s = int'(x[i]) - int'(y[i]);
            r[i] = (s < 0);
        end
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_r1 = 1'b0; b_r1 = 1'b1;
        a_r4 = 4'b0011; b_r4 = 4'b1111;
        a_r8 = 8'h0F; b_r8 = 8'hF0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (diff_r1 !== 1'b0 || bo_r1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_r1 got diff=%b bo=%b want 0 0", diff_r1, bo_r1);
        end
        checks++;
        if (diff_r4 !== 4'd0 || bo_r4 !== 4'd0) begin
            failures++;
            $display("FAIL reset_r4 got diff=%b bo=%b want 0000 0000", diff_r4, bo_r4);
        end
        checks++;
        if (diff_r8 !== 8'd0 || bo_r8 !== 8'd0) begin
            failures++;
            $display("FAIL reset_r8 got diff=%h bo=%h want 00 00", diff_r8, bo_r8);
        end
    endtask

    task automatic test_comb_sweep();
        logic [3:0] exp_d;
        logic [3:0] exp_b;
        exp_d = 4'b0110;  // index {a,b}: 00,01,10,11
        exp_b = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_c1 = k[1];
            b_c1 = k[0];
            #1;
            checks++;
            if (diff_c1 !== exp_d[k] || bo_c1 !== exp_b[k]) begin
                failures++;
                $display("FAIL comb_sweep a=%b b=%b got diff=%b bo=%b want %b %b",
                         a_c1, b_c1, diff_c1, bo_c1, exp_d[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        rst_n = 1'b1;
        a_r1 = 1'b0; b_r1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_r1 = 1'b0; b_r1 = 1'b1;
        #1;
        checks++;
        if (diff_r1 !== 1'b0 || bo_r1 !== 1'b0) begin
            failures++;
            $display("FAIL latency_before got diff=%b bo=%b want 0 0", diff_r1, bo_r1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (diff_r1 !== 1'b1 || bo_r1 !== 1'b1) begin
            failures++;
            $display("FAIL latency_after got diff=%b bo=%b want 1 1", diff_r1, bo_r1);
        end
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        rst_n = 1'b0;
        a_r1 = 1'b0; b_r1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (diff_r1 !== 1'b0 || bo_r1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold edge=%0d got diff=%b bo=%b want 0 0", k, diff_r1, bo_r1);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (diff_r1 !== 1'b1 || bo_r1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got diff=%b bo=%b want 1 1", diff_r1, bo_r1);
        end
    endtask

    task automatic test_lanes();
        @(negedge clk);
        rst_n = 1'b1;
        a_r4 = 4'b1100;
        b_r4 = 4'b1010;
        @(posedge clk);
        #1;
        checks++;
        if (diff_r4 !== 4'b0110 || bo_r4 !== 4'b0010) begin
            failures++;
            $display("FAIL lanes_w4 got diff=%b bo=%b want 0110 0010", diff_r4, bo_r4);
        end
    endtask

    // Random streams on both builds, with one-cycle reset pulses mid-stream.
    task automatic test_random();
        logic [7:0] exp_d;
        logic [7:0] exp_b;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            a_c8 = 8'($urandom);
            b_c8 = 8'($urandom);
            a_r8 = 8'($urandom);
            b_r8 = 8'($urandom);
            rst_n = (cyc == 300 || cyc == 700) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (diff_c8 !== ref_diff(a_c8, b_c8) || bo_c8 !== ref_bo(a_c8, b_c8)) begin
                failures++;
                $display("FAIL random_comb cyc=%0d a=%h b=%h got diff=%h bo=%h want %h %h",
                         cyc, a_c8, b_c8, diff_c8, bo_c8, ref_diff(a_c8, b_c8), ref_bo(a_c8, b_c8));
            end
            exp_d = rst_n ? ref_diff(a_r8, b_r8) : 8'd0;
            exp_b = rst_n ? ref_bo(a_r8, b_r8) : 8'd0;
            @(posedge clk);
            #1;
            checks++;
            if (diff_r8 !== exp_d || bo_r8 !== exp_b) begin
                failures++;
                $display("FAIL random_reg cyc=%0d rst_n=%b got diff=%h bo=%h want %h %h",
                         cyc, rst_n, diff_r8, bo_r8, exp_d, exp_b);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a_c1 = 1'b0; b_c1 = 1'b0;
        a_r1 = 1'b0; b_r1 = 1'b0;
        a_r4 = 4'd0; b_r4 = 4'd0;
        a_c8 = 8'd0; b_c8 = 8'd0;
        a_r8 = 8'd0; b_r8 = 8'd0;

        test_reset();
        test_comb_sweep();
        test_latency();
        test_reset_hold();
        test_lanes();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
